// File: rtl/char_action_resolver.sv
// Per-player action resolver: applies movement, drives the attack hitbox and
// registers landed hits, all sampled from the character state code on frame ticks.
module char_action_resolver #(
  parameter logic [9:0] START_X   = 10'd100,
  parameter logic [9:0] X_MIN     = 10'd0,
  parameter logic [9:0] X_MAX     = 10'd576,
  parameter logic [9:0] MOVE_STEP = 10'd3,
  parameter logic [9:0] CHAR_W    = 10'd64,
  parameter logic [9:0] RANGE_N   = 10'd32,
  parameter logic [9:0] RANGE_D   = 10'd48,
  parameter logic       FACE_LEFT = 1'b0
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       FRAME_TICK,
  input  logic [3:0] STATE,
  input  logic [9:0] OPP_X,
  output logic [9:0] CHAR_X,
  output logic       HITBOX_ACTIVE,
  output logic [9:0] HITBOX_L,
  output logic [9:0] HITBOX_R,
  output logic [2:0] SPRITE_SEL,
  output logic       HIT_PULSE,
  output logic [7:0] HIT_COUNT,
  output logic       STATE_ERR
);

  typedef enum logic [1:0] {H_IDLE, H_ARMED, H_CONNECTED} hit_state_t;
  hit_state_t hit_state;

  logic        legal;
  logic [3:0]  st;
  logic [10:0] x_ext, x_left, x_right, width, l_raw, r_raw, opp_end;
  logic [9:0]  next_x, box_l, box_r;
  logic        attack_active, start_state, neutral_state, overlap;
  logic [2:0]  sprite;

  // Illegal codes collapse to IDLE before any decoding, so they can never move or hit.
  always_comb begin
    legal         = (STATE <= 4'd8);
    st            = legal ? STATE : 4'd0;
    x_ext         = {1'b0, CHAR_X};
    x_left        = x_ext - {1'b0, MOVE_STEP};
    x_right       = x_ext + {1'b0, MOVE_STEP};
    attack_active = (st == 4'd4) || (st == 4'd7);
    start_state   = (st == 4'd3) || (st == 4'd6);
    neutral_state = (st <= 4'd2);
    width         = {1'b0, (st == 4'd7) ? RANGE_D : RANGE_N};

    next_x = CHAR_X;
    if (st == 4'd1)
      next_x = (x_left[10] || (x_left < {1'b0, X_MIN})) ? X_MIN : x_left[9:0];
    else if (st == 4'd2)
      next_x = (x_right > {1'b0, X_MAX}) ? X_MAX : x_right[9:0];

    // Right-facing boxes clamp at the screen edge; left-facing ones clamp at zero.
    l_raw = '0;
    r_raw = '0;
    box_l = '0;
    box_r = '0;
    if (!FACE_LEFT) begin
      l_raw = x_ext + {1'b0, CHAR_W};
      r_raw = l_raw + width - 11'd1;
      box_l = (l_raw > 11'd1023) ? 10'd1023 : l_raw[9:0];
      box_r = (r_raw > 11'd1023) ? 10'd1023 : r_raw[9:0];
    end else begin
      box_l = (x_ext >= width) ? (CHAR_X - width[9:0]) : 10'd0;
      box_r = (CHAR_X != 10'd0) ? (CHAR_X - 10'd1) : 10'd0;
    end

    opp_end = {1'b0, OPP_X} + {1'b0, CHAR_W} - 11'd1;
    overlap = ({1'b0, box_l} <= opp_end) && (OPP_X <= box_r);

    case (st)
      4'd0:    sprite = 3'd0;
      4'd1:    sprite = 3'd1;
      4'd2:    sprite = 3'd2;
      4'd4:    sprite = 3'd4;
      4'd7:    sprite = 3'd5;
      default: sprite = 3'd3;
    endcase
  end

  // Everything, including the hit FSM, advances only on frame ticks; the pulse self-clears.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      CHAR_X        <= START_X;
      HITBOX_ACTIVE <= 1'b0;
      HITBOX_L      <= '0;
      HITBOX_R      <= '0;
      SPRITE_SEL    <= '0;
      HIT_PULSE     <= 1'b0;
      HIT_COUNT     <= '0;
      STATE_ERR     <= 1'b0;
      hit_state     <= H_IDLE;
    end else begin
      HIT_PULSE <= 1'b0;
      if (FRAME_TICK) begin
        CHAR_X        <= next_x;
        HITBOX_ACTIVE <= attack_active;
        HITBOX_L      <= attack_active ? box_l : 10'd0;
        HITBOX_R      <= attack_active ? box_r : 10'd0;
        SPRITE_SEL    <= sprite;
        if (!legal)
          STATE_ERR <= 1'b1;
        case (hit_state)
          H_IDLE:
            if (start_state)
              hit_state <= H_ARMED;
          H_ARMED:
            if (neutral_state)
              hit_state <= H_IDLE;
            else if (attack_active && overlap) begin
              hit_state <= H_CONNECTED;
              HIT_PULSE <= 1'b1;
              if (HIT_COUNT != 8'd255)
                HIT_COUNT <= HIT_COUNT + 8'd1;
            end
          H_CONNECTED:
            if (neutral_state)
              hit_state <= H_IDLE;
          default:
            hit_state <= H_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_char_action_resolver.sv
// Bench for char_action_resolver: a right-facing and a left-facing instance share
// one directed stimulus stream and are checked every cycle against a behavioural model.
module tb_char_action_resolver;

  logic       clock = 1'b0;
  logic       resetN;
  logic       frameTick;
  logic [3:0] stateCode;
  logic [9:0] oppX;

  logic [9:0] charXR, hitLR, hitRR, charXL, hitLL, hitRL;
  logic       actR, pulseR, errR, actL, pulseL, errL;
  logic [2:0] spriteR, spriteL;
  logic [7:0] countR, countL;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  char_action_resolver #(.FACE_LEFT(1'b0)) dutR (
    .CLOCK(clock), .RESET_N(resetN), .FRAME_TICK(frameTick), .STATE(stateCode), .OPP_X(oppX),
    .CHAR_X(charXR), .HITBOX_ACTIVE(actR), .HITBOX_L(hitLR), .HITBOX_R(hitRR),
    .SPRITE_SEL(spriteR), .HIT_PULSE(pulseR), .HIT_COUNT(countR), .STATE_ERR(errR)
  );

  char_action_resolver #(.FACE_LEFT(1'b1)) dutL (
    .CLOCK(clock), .RESET_N(resetN), .FRAME_TICK(frameTick), .STATE(stateCode), .OPP_X(oppX),
    .CHAR_X(charXL), .HITBOX_ACTIVE(actL), .HITBOX_L(hitLL), .HITBOX_R(hitRL),
    .SPRITE_SEL(spriteL), .HIT_PULSE(pulseL), .HIT_COUNT(countL), .STATE_ERR(errL)
  );

  // One player's observable state plus the attack bookkeeping that decides if a hit may land.
  typedef struct packed {
    int x;
    bit act;
    int l;
    int r;
    int sprite;
    bit pulse;
    int count;
    bit err;
    bit inAttack;
    bit landed;
  } model_t;

  model_t expR, expL;

  function automatic model_t resetModel();
    model_t m;
    m = '0;
    m.x = 100;
    return m;
  endfunction

  function automatic model_t modelStep(model_t m, int stIn, int opp, bit faceLeft);
    model_t n;
    int st, width, lo, hi;
    bit overlap;
    n = m;
    n.pulse = 1'b0;
    st = stIn;
    if (st > 8) begin
      n.err = 1'b1;
      st = 0;
    end
    if (st == 1) n.x = (m.x - 3 < 0) ? 0 : m.x - 3;
    if (st == 2) n.x = (m.x + 3 > 576) ? 576 : m.x + 3;
    case (st)
      0: n.sprite = 0;
      1: n.sprite = 1;
      2: n.sprite = 2;
      4: n.sprite = 4;
      7: n.sprite = 5;
      default: n.sprite = 3;
    endcase
    n.act = (st == 4) || (st == 7);
    lo = 0;
    hi = 0;
    if (n.act) begin
      width = (st == 4) ? 32 : 48;
      if (!faceLeft) begin
        lo = m.x + 64;
        hi = lo + width - 1;
        if (lo > 1023) lo = 1023;
        if (hi > 1023) hi = 1023;
      end else begin
        hi = m.x - 1;
        lo = m.x - width;
        if (hi < 0) hi = 0;
        if (lo < 0) lo = 0;
      end
    end
    n.l = lo;
    n.r = hi;
    overlap = n.act && (lo <= opp + 63) && (opp <= hi);
    if (st == 3 || st == 6)
      n.inAttack = 1'b1;
    else if (st <= 2) begin
      n.inAttack = 1'b0;
      n.landed   = 1'b0;
    end else if (overlap && n.inAttack && !n.landed) begin
      n.landed = 1'b1;
      n.pulse  = 1'b1;
      if (n.count < 255) n.count = n.count + 1;
    end
    return n;
  endfunction

  // The model follows the same tick/reset timing as the design but from its own rules.
  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      expR <= resetModel();
      expL <= resetModel();
    end else if (frameTick) begin
      expR <= modelStep(expR, int'(stateCode), int'(oppX), 1'b0);
      expL <= modelStep(expL, int'(stateCode), int'(oppX), 1'b1);
    end else begin
      expR.pulse <= 1'b0;
      expL.pulse <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Every cycle, away from the rising edge, both instances must match the model.
  always @(negedge clock) begin
    checkOutput("R charX",  int'(charXR),  expR.x);
    checkOutput("R active", int'(actR),    int'(expR.act));
    checkOutput("R boxL",   int'(hitLR),   expR.l);
    checkOutput("R boxR",   int'(hitRR),   expR.r);
    checkOutput("R sprite", int'(spriteR), expR.sprite);
    checkOutput("R pulse",  int'(pulseR),  int'(expR.pulse));
    checkOutput("R count",  int'(countR),  expR.count);
    checkOutput("R err",    int'(errR),    int'(expR.err));
    checkOutput("L charX",  int'(charXL),  expL.x);
    checkOutput("L active", int'(actL),    int'(expL.act));
    checkOutput("L boxL",   int'(hitLL),   expL.l);
    checkOutput("L boxR",   int'(hitRL),   expL.r);
    checkOutput("L sprite", int'(spriteL), expL.sprite);
    checkOutput("L pulse",  int'(pulseL),  int'(expL.pulse));
    checkOutput("L count",  int'(countL),  expL.count);
    checkOutput("L err",    int'(errL),    int'(expL.err));
  end

  // One tick with the given code; returns at the next falling edge with OPP_X scrambled.
  task automatic applyStimulus(input int st, input int opp);
    frameTick = 1'b1;
    stateCode = 4'(st);
    oppX      = 10'(opp);
    @(negedge clock);
    frameTick = 1'b0;
    oppX      = 10'(opp) ^ 10'h155;
  endtask

  task automatic pulseReset();
    resetN = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN    = 1'b0;
    frameTick = 1'b0;
    stateCode = 4'd0;
    oppX      = 10'd0;
    repeat (2) @(negedge clock);
    checkOutput("reset charX", int'(charXR), 100);
    checkOutput("reset count", int'(countR), 0);
    resetN = 1'b1;

    // Walking right from the start position, then both screen-edge clamps.
    applyStimulus(2, 0);
    checkOutput("walk 103", int'(charXR), 103);
    applyStimulus(2, 0);
    applyStimulus(2, 0);
    checkOutput("walk 109", int'(charXR), 109);
    checkOutput("walk sprite", int'(spriteR), 2);
    repeat (2) @(negedge clock);
    checkOutput("hold between ticks", int'(charXR), 109);
    repeat (160) applyStimulus(2, 0);
    checkOutput("clamp right", int'(charXR), 576);
    repeat (200) applyStimulus(1, 0);
    checkOutput("clamp left", int'(charXR), 0);
    checkOutput("left sprite", int'(spriteR), 1);

    // Neutral attack that overlaps for three active frames: exactly one hit.
    pulseReset();
    applyStimulus(3, 180);
    checkOutput("windup pulse", int'(pulseR), 0);
    applyStimulus(4, 180);
    checkOutput("hit pulse", int'(pulseR), 1);
    checkOutput("hit count", int'(countR), 1);
    checkOutput("box left", int'(hitLR), 164);
    checkOutput("box right", int'(hitRR), 195);
    checkOutput("mirror box left", int'(hitLL), 68);
    checkOutput("mirror box right", int'(hitRL), 99);
    @(negedge clock);
    checkOutput("pulse clears", int'(pulseR), 0);
    applyStimulus(4, 180);
    applyStimulus(4, 180);
    checkOutput("no second hit", int'(pulseR), 0);
    checkOutput("count holds", int'(countR), 1);

    // Directional attack out of reach, then an unarmed active frame.
    applyStimulus(0, 260);
    applyStimulus(6, 260);
    applyStimulus(7, 260);
    checkOutput("dir box right", int'(hitRR), 211);
    checkOutput("dir miss", int'(pulseR), 0);
    checkOutput("dir sprite", int'(spriteR), 5);
    applyStimulus(8, 260);
    applyStimulus(0, 260);
    applyStimulus(4, 180);
    checkOutput("unarmed no pulse", int'(pulseR), 0);
    checkOutput("unarmed count", int'(countR), 1);

    // Illegal code is sticky; reset in the middle of an attack is immediate.
    applyStimulus(12, 180);
    checkOutput("illegal err", int'(errR), 1);
    checkOutput("illegal active", int'(actR), 0);
    applyStimulus(2, 180);
    applyStimulus(1, 180);
    checkOutput("err sticky", int'(errR), 1);
    applyStimulus(3, 180);
    applyStimulus(4, 180);
    checkOutput("second hit", int'(countR), 2);
    #3 resetN = 1'b0;
    #1;
    checkOutput("async charX", int'(charXR), 100);
    checkOutput("async active", int'(actR), 0);
    checkOutput("async boxR", int'(hitRR), 0);
    checkOutput("async count", int'(countR), 0);
    checkOutput("async err", int'(errR), 0);
    checkOutput("async sprite", int'(spriteR), 0);
    @(negedge clock);
    resetN = 1'b1;
    applyStimulus(4, 180);
    checkOutput("post reset unarmed", int'(pulseR), 0);

    // Hit counter saturation.
    applyStimulus(0, 180);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(3, 180);
      applyStimulus(4, 180);
      applyStimulus(0, 180);
    end
    checkOutput("count saturates", int'(countR), 255);

    // Left-facing hitbox near and at the left edge.
    repeat (27) applyStimulus(1, 0);
    checkOutput("mirror x", int'(charXL), 19);
    applyStimulus(4, 0);
    checkOutput("mirror clamp L", int'(hitLL), 0);
    checkOutput("mirror clamp R", int'(hitRL), 18);
    applyStimulus(0, 0);
    applyStimulus(3, 0);
    applyStimulus(4, 0);
    checkOutput("mirror hit", int'(pulseL), 1);
    applyStimulus(0, 0);
    repeat (10) applyStimulus(1, 0);
    applyStimulus(7, 0);
    checkOutput("zero x boxL", int'(hitLL), 0);
    checkOutput("zero x boxR", int'(hitRL), 0);
    checkOutput("zero x right boxR", int'(hitRR), 111);
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
